// File: rtl/mips_cpu_alu_decoder.sv
// Decode stage: MIPS-I instruction word -> registered ALU controls, 1-entry output register + 1-entry skid buffer.
// Optional DEC_PERF_CNT_EN adds perf_decoded/perf_stall counters (reset-cleared, wrap modulo 2^CNT_W).
module mips_cpu_alu_decoder #(
  parameter int FUNC_W = 5
`ifdef DEC_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FUNC_W-1:0] dec_alu_func,
  output logic [4:0]        dec_shift,
  output logic              dec_use_imm,
  output logic              dec_a_zero,
  output logic [31:0]       dec_imm,
  output logic              dec_illegal
`ifdef DEC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_decoded,
  output logic [CNT_W-1:0]  perf_stall
`endif
);

  localparam logic [FUNC_W-1:0] ALU_ADDU = FUNC_W'(5'b00000);
  localparam logic [FUNC_W-1:0] ALU_AND  = FUNC_W'(5'b00001);
  localparam logic [FUNC_W-1:0] ALU_OR   = FUNC_W'(5'b00010);
  localparam logic [FUNC_W-1:0] ALU_SUBU = FUNC_W'(5'b00011);
  localparam logic [FUNC_W-1:0] ALU_SLT  = FUNC_W'(5'b00100);
  localparam logic [FUNC_W-1:0] ALU_SLTU = FUNC_W'(5'b00101);
  localparam logic [FUNC_W-1:0] ALU_SLL  = FUNC_W'(5'b00110);
  localparam logic [FUNC_W-1:0] ALU_SLLV = FUNC_W'(5'b00111);
  localparam logic [FUNC_W-1:0] ALU_SRL  = FUNC_W'(5'b01000);
  localparam logic [FUNC_W-1:0] ALU_SRLV = FUNC_W'(5'b01001);
  localparam logic [FUNC_W-1:0] ALU_SRA  = FUNC_W'(5'b01010);
  localparam logic [FUNC_W-1:0] ALU_SRAV = FUNC_W'(5'b01011);
  localparam logic [FUNC_W-1:0] ALU_XOR  = FUNC_W'(5'b01100);
  localparam logic [FUNC_W-1:0] ALU_BGEZ = FUNC_W'(5'b01101);
  localparam logic [FUNC_W-1:0] ALU_BGTZ = FUNC_W'(5'b01110);
  localparam logic [FUNC_W-1:0] ALU_BLEZ = FUNC_W'(5'b01111);
  localparam logic [FUNC_W-1:0] ALU_BLTZ = FUNC_W'(5'b10000);
  localparam logic [FUNC_W-1:0] ALU_BNE  = FUNC_W'(5'b10001);
  localparam logic [FUNC_W-1:0] ALU_BEQ  = FUNC_W'(5'b10010);

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [4:0]        shift;
    logic              use_imm;
    logic              a_zero;
    logic [31:0]       imm;
    logic              illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_e;

  state_e state_q, state_d;
  dec_t   out_q, out_d;
  dec_t   skid_q, skid_d;
  dec_t   dec_new;
  logic   in_fire;
  logic   out_fire;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign imm_sext = {{16{in_instr[15]}}, in_instr[15:0]};
  assign imm_zext = {16'h0000, in_instr[15:0]};

  // Matching on the whole word keeps the table readable as op/rs/rt/rd/sa/funct fields.
  always_comb begin
    dec_new         = '0;
    dec_new.func    = ALU_ADDU;
    dec_new.shift   = in_instr[10:6];
    casez (in_instr)
      32'b000000_?????_?????_?????_?????_100001: dec_new.func = ALU_ADDU;
      32'b000000_?????_?????_?????_?????_100100: dec_new.func = ALU_AND;
      32'b000000_?????_?????_?????_?????_100101: dec_new.func = ALU_OR;
      32'b000000_?????_?????_?????_?????_100011: dec_new.func = ALU_SUBU;
      32'b000000_?????_?????_?????_?????_101010: dec_new.func = ALU_SLT;
      32'b000000_?????_?????_?????_?????_101011: dec_new.func = ALU_SLTU;
      32'b000000_?????_?????_?????_?????_000000: dec_new.func = ALU_SLL;
      32'b000000_?????_?????_?????_?????_000100: dec_new.func = ALU_SLLV;
      32'b000000_?????_?????_?????_?????_000010: dec_new.func = ALU_SRL;
      32'b000000_?????_?????_?????_?????_000110: dec_new.func = ALU_SRLV;
      32'b000000_?????_?????_?????_?????_000011: dec_new.func = ALU_SRA;
      32'b000000_?????_?????_?????_?????_000111: dec_new.func = ALU_SRAV;
      32'b000000_?????_?????_?????_?????_100110: dec_new.func = ALU_XOR;
      32'b001001_?????_?????_????????????????,
      32'b100011_?????_?????_????????????????,
      32'b101011_?????_?????_????????????????: begin
        dec_new.func    = ALU_ADDU;
        dec_new.use_imm = 1'b1;
        dec_new.imm     = imm_sext;
      end
      32'b001010_?????_?????_????????????????: begin
        dec_new.func    = ALU_SLT;
        dec_new.use_imm = 1'b1;
        dec_new.imm     = imm_sext;
      end
      32'b001011_?????_?????_????????????????: begin
        dec_new.func    = ALU_SLTU;
        dec_new.use_imm = 1'b1;
        dec_new.imm     = imm_sext;
      end
      32'b001100_?????_?????_????????????????: begin
        dec_new.func    = ALU_AND;
        dec_new.use_imm = 1'b1;
        dec_new.imm     = imm_zext;
      end
      32'b001101_?????_?????_????????????????: begin
        dec_new.func    = ALU_OR;
        dec_new.use_imm = 1'b1;
        dec_new.imm     = imm_zext;
      end
      32'b001110_?????_?????_????????????????: begin
        dec_new.func    = ALU_XOR;
        dec_new.use_imm = 1'b1;
        dec_new.imm     = imm_zext;
      end
      // LUI is computed as 0 | (imm << 16), hence the forced-zero A operand.
      32'b001111_?????_?????_????????????????: begin
        dec_new.func    = ALU_OR;
        dec_new.use_imm = 1'b1;
        dec_new.a_zero  = 1'b1;
        dec_new.imm     = {in_instr[15:0], 16'h0000};
      end
      32'b000100_?????_?????_????????????????: dec_new.func = ALU_BEQ;
      32'b000101_?????_?????_????????????????: dec_new.func = ALU_BNE;
      32'b000110_?????_?????_????????????????: dec_new.func = ALU_BLEZ;
      32'b000111_?????_?????_????????????????: dec_new.func = ALU_BGTZ;
      32'b000001_?????_00000_????????????????: dec_new.func = ALU_BLTZ;
      32'b000001_?????_00001_????????????????: dec_new.func = ALU_BGEZ;
      default: dec_new.illegal = 1'b1;
    endcase
  end

  // in_ready comes straight from the state register, so it never depends on out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            out_d   = dec_new;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_d = dec_new;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = dec_new;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign dec_alu_func = out_q.func;
  assign dec_shift    = out_q.shift;
  assign dec_use_imm  = out_q.use_imm;
  assign dec_a_zero   = out_q.a_zero;
  assign dec_imm      = out_q.imm;
  assign dec_illegal  = out_q.illegal;

`ifdef DEC_PERF_CNT_EN
  logic [CNT_W-1:0] perf_decoded_q, perf_decoded_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

  // A handshake coinciding with flush is discarded, so it is not counted as decoded.
  always_comb begin
    perf_decoded_d = perf_decoded_q;
    perf_stall_d   = perf_stall_q;
    if (out_fire && !flush) perf_decoded_d = perf_decoded_q + 1'b1;
    if (out_valid && !out_ready) perf_stall_d = perf_stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_decoded_q <= perf_decoded_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_mips_cpu_alu_decoder.sv
// Directed bench for mips_cpu_alu_decoder: reset, decode table, backpressure ordering, flush.
module tb_mips_cpu_alu_decoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  dec_alu_func;
  logic [4:0]  dec_shift;
  logic        dec_use_imm;
  logic        dec_a_zero;
  logic [31:0] dec_imm;
  logic        dec_illegal;
`ifdef DEC_PERF_CNT_EN
  logic [31:0] perf_decoded;
  logic [31:0] perf_stall;
  int          exp_dec;
  int          exp_stall;
`endif

  int checks;
  int failures;

  mips_cpu_alu_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .dec_alu_func (dec_alu_func),
    .dec_shift    (dec_shift),
    .dec_use_imm  (dec_use_imm),
    .dec_a_zero   (dec_a_zero),
    .dec_imm      (dec_imm),
    .dec_illegal  (dec_illegal)
`ifdef DEC_PERF_CNT_EN
    ,
    .perf_decoded (perf_decoded),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
`ifdef DEC_PERF_CNT_EN
    if (rst_n && out_valid && out_ready && !flush) exp_dec++;
    if (rst_n && out_valid && !out_ready) exp_stall++;
`endif
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] sa, input logic [5:0] funct);
    return {6'b000000, 5'd1, 5'd2, 5'd3, sa, funct};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd4, rt, imm};
  endfunction

  // Present one word with out_ready=1 and check the decoded controls one cycle later.
  task automatic send_chk(input string tag, input logic [31:0] instr, input logic [4:0] func,
                          input logic [4:0] shift, input logic use_imm, input logic a_zero,
                          input logic [31:0] imm, input logic illegal);
    in_valid = 1'b1;
    in_instr = instr;
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".func"}, {27'b0, dec_alu_func}, {27'b0, func});
    chk({tag, ".shift"}, {27'b0, dec_shift}, {27'b0, shift});
    chk({tag, ".use_imm"}, {31'b0, dec_use_imm}, {31'b0, use_imm});
    chk({tag, ".a_zero"}, {31'b0, dec_a_zero}, {31'b0, a_zero});
    chk({tag, ".imm"}, dec_imm, imm);
    chk({tag, ".illegal"}, {31'b0, dec_illegal}, {31'b0, illegal});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
`ifdef DEC_PERF_CNT_EN
    exp_dec   = 0;
    exp_stall = 0;
`endif
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    out_ready = 1'b0;
    #1;
    chk("por.out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("por.in_ready", {31'b0, in_ready}, 32'd1);

    // Reset in the middle of a transfer: buffered SUBU must disappear.
    in_valid = 1'b1;
    in_instr = r_op(5'd0, 6'b100011);
    tick();
    in_valid = 1'b0;
    chk("rst.pre_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.func", {27'b0, dec_alu_func}, 32'd0);
    chk("rst.imm", dec_imm, 32'd0);
    tick();
    rst_n = 1'b1;
`ifdef DEC_PERF_CNT_EN
    exp_dec   = 0;
    exp_stall = 0;
    chk("rst.perf_decoded", perf_decoded, 32'd0);
`endif
    #1;
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("rst.discarded", {31'b0, out_valid}, 32'd0);

    // Back-to-back R-type stream.
    out_ready = 1'b1;
    send_chk("addu", r_op(5'd0, 6'b100001), 5'b00000, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_chk("subu", r_op(5'd0, 6'b100011), 5'b00011, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_chk("sra",  r_op(5'd3, 6'b000011), 5'b01010, 5'd3, 1'b0, 1'b0, 32'h0, 1'b0);
    send_chk("xor",  r_op(5'd0, 6'b100110), 5'b01100, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Immediates.
    send_chk("addiu", i_op(6'b001001, 5'd5, 16'hFFFF), 5'b00000, 5'd31, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0);
    send_chk("ori",   i_op(6'b001101, 5'd5, 16'hFFFF), 5'b00010, 5'd31, 1'b1, 1'b0, 32'h0000FFFF, 1'b0);
    send_chk("lui",   i_op(6'b001111, 5'd5, 16'h1234), 5'b00010, 5'd8,  1'b1, 1'b1, 32'h12340000, 1'b0);
    send_chk("sltiu", i_op(6'b001011, 5'd5, 16'h8000), 5'b00101, 5'd0,  1'b1, 1'b0, 32'hFFFF8000, 1'b0);
    send_chk("lw",    i_op(6'b100011, 5'd5, 16'h0040), 5'b00000, 5'd1,  1'b1, 1'b0, 32'h00000040, 1'b0);

    // Branches and illegal encodings.
    send_chk("beq",    i_op(6'b000100, 5'd6, 16'h0), 5'b10010, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_chk("bne",    i_op(6'b000101, 5'd6, 16'h0), 5'b10001, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_chk("bltz",   i_op(6'b000001, 5'd0, 16'h0), 5'b10000, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_chk("bgez",   i_op(6'b000001, 5'd1, 16'h0), 5'b01101, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    send_chk("regimm2", i_op(6'b000001, 5'd2, 16'h0), 5'b00000, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    send_chk("op3f",   i_op(6'b111111, 5'd0, 16'h00AB), 5'b00000, 5'd2, 1'b0, 1'b0, 32'h0, 1'b1);
    send_chk("funct3f", r_op(5'd5, 6'b111111), 5'b00000, 5'd5, 1'b0, 1'b0, 32'h0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("drain.out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: A=SUBU, B=SLT, C=SRL with out_ready low for three edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = r_op(5'd0, 6'b100011);
    chk("bp.rdy_a", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp.out_a", {27'b0, dec_alu_func}, 32'd3);
    in_instr = r_op(5'd0, 6'b101010);
    chk("bp.rdy_b", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp.rdy_after_b", {31'b0, in_ready}, 32'd0);
    chk("bp.hold_a", {27'b0, dec_alu_func}, 32'd3);
    in_instr = r_op(5'd0, 6'b000010);
    tick();
    chk("bp.rdy_c", {31'b0, in_ready}, 32'd0);
    chk("bp.hold_a2", {27'b0, dec_alu_func}, 32'd3);
    chk("bp.valid_a", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp.out_b", {27'b0, dec_alu_func}, 32'd4);
    chk("bp.rdy_c2", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.out_c", {27'b0, dec_alu_func}, 32'd8);
    chk("bp.valid_c", {31'b0, out_valid}, 32'd1);
    tick();
    chk("bp.empty", {31'b0, out_valid}, 32'd0);

    // Flush while both entries are full and a new word is offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = r_op(5'd0, 6'b100100);
    tick();
    in_instr = r_op(5'd0, 6'b100101);
    tick();
    chk("fl.full", {31'b0, in_ready}, 32'd0);
    flush    = 1'b1;
    in_instr = r_op(5'd0, 6'b100110);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl.in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl.no_emit", {31'b0, out_valid}, 32'd0);
    end
`ifdef DEC_PERF_CNT_EN
    chk("fl.perf_decoded", perf_decoded, 32'(exp_dec));
    chk("fl.perf_stall", perf_stall, 32'(exp_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
